pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Decode-side hazard controller that feeds the ID/EX pipeline register. It keeps its own shadow copy of destination-register info for the EX and MEM stages and uses it for three things: it selects operand bypass sources for da/db, detects load-use hazards, and stalls IF/ID while injecting a bubble into ID/EX. It also keeps saturating stall and bypass event counters for performance debug.

Parameters:
CNT_W, 32, width of the stall_cnt and fwd_cnt counters.
BYPASS_EN, 1, 1 = forwarding enabled; 0 = no forwarding, and every RAW hazard against EX or MEM stalls.

Ports:
clock  input  1  system clock, rising-edge.
resetn  input  1  reset, synchronous, active-low.
d_rs  input  5  rs field of the instruction in decode.
d_rt  input  5  rt field of the instruction in decode.
d_use_rs  input  1  decode instruction reads rs.
d_use_rt  input  1  decode instruction reads rt.
d_wreg  input  1  decode instruction writes the register file.
d_m2reg  input  1  decode instruction is a load.
d_rn  input  5  destination register of the decode instruction.
fwda  output  2  da source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
fwdb  output  2  db source, same encoding as fwda.
wpcir  output  1  1 = PC and IF/ID update; 0 = hold (stall).
bubble  output  1  1 = force dwreg/dm2reg/dwmem to 0 into ID/EX.
stall_cnt  output  CNT_W  number of stall cycles since reset.
fwd_cnt  output  CNT_W  number of cycles with at least one used operand forwarded.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Shadow state: e_wreg, e_m2reg, e_rn[4:0], m_wreg, m_m2reg, m_rn[4:0].
- Shadow update on each rising clock:
  - e_* <= bubble ? 0 : d_*
  - m_* <= e_*
- While resetn==0 at a rising edge: all shadow regs and both counters clear to 0. Reset mid-stall drops the stall in the following cycle, because the shadow state has cleared.
- Register $0 never matches: any compare where the destination is 0 is false.
- The register file writes before it is read within a cycle, so there is no WB-stage forwarding.
- Match terms:
  - hitE(x) = e_wreg & (e_rn!=0) & (e_rn==x)
  - hitM(x) = m_wreg & (m_rn!=0) & (m_rn==x)
- Forwarding (BYPASS_EN=1), combinational from shadow state and d_* in the same cycle, evaluated per operand x in {rs, rt}:
  - hitE(x) & !e_m2reg -> 01
  - else hitM(x) -> 11 if m_m2reg, otherwise 10
  - else 00
  - EX has priority over MEM when both match (EX holds the younger writer).
  - A load in EX matching x gives 00 (the stall covers it).
  - fwd outputs ignore the use bits.
- Stall, BYPASS_EN=1:
  - stall = e_wreg & e_m2reg & (e_rn!=0) & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt))
- Stall, BYPASS_EN=0:
  - stall = any used operand with hitE or hitM.
  - fwda = fwdb = 00 always.
- Outputs from stall: wpcir = !stall; bubble = stall. A load-use hazard costs exactly 1 cycle with bypass on; without bypass a RAW hazard costs 1–2 cycles.
- stall_cnt: +1 on each clock where stall==1. Saturates at all-ones (no wrap).
- fwd_cnt: +1 on each clock where (d_use_rs & fwda!=00) | (d_use_rt & fwdb!=00). Saturates at all-ones.
- A stalled cycle is not counted in fwd_cnt.
- Counters and shadow regs are the only registers; all other outputs are combinational.
- Reset values:
  - Counters read 0 on the cycle after reset.
  - With shadow state clear: wpcir=1, bubble=0, fwda=fwdb=00.

Test Plan:
1. Reset then idle: hold resetn=0 for 2 clocks with random d_* values, then release with d_wreg=0 -> wpcir=1, bubble=0, fwda=fwdb=00, stall_cnt=fwd_cnt=0.
2. ALU chain: issue add r3 (d_wreg=1, d_rn=3), then a reader with d_rs=3, d_use_rs=1 on the next cycle -> fwda=01 in that cycle, fwd_cnt=1 after the edge. Keep the reader one cycle later (rt=3) -> fwdb=10.
3. Load-use: issue lw r5 (d_wreg=1, d_m2reg=1, d_rn=5), then a reader with d_rt=5, d_use_rt=1:
   - first cycle -> wpcir=0, bubble=1.
   - next cycle, same inputs held -> wpcir=1, fwdb=11.
   - stall_cnt ends at 1.
4. $0 and priority:
   - writer with d_rn=0 followed by reader rs=0 -> fwda=00, no stall.
   - two back-to-back writers of r7 followed by reader rs=7 -> fwda=01 (EX wins).
5. BYPASS_EN=0: add r4 followed by a reader with rs=4 -> stall for 2 cycles, then fwda=00. stall_cnt=2.
6. Saturation and reset mid-op:
   - CNT_W=4, 20 consecutive load-use stalls -> stall_cnt sticks at 15.
   - resetn=0 while a stall is active -> after the edge, stall_cnt=0, bubble=0, wpcir=1.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Decode-side hazard controller for a classic 5-stage pipeline.
// Keeps a shadow copy of the EX/MEM destination info and uses it to pick
// the operand bypass sources, detect RAW/load-use hazards, and stall
// IF/ID while a bubble is pushed into ID/EX. Saturating stall and
// forward counters are provided for performance debug.
module pipe_hazard_unit #(
  parameter int CNT_W     = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_wreg,
  input  logic             d_m2reg,
  input  logic [4:0]       d_rn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  // Operand source encodings driven on fwda/fwdb.
  localparam logic [1:0] SRC_RF      = 2'b00;
  localparam logic [1:0] SRC_EX_ALU  = 2'b01;
  localparam logic [1:0] SRC_MEM_ALU = 2'b10;
  localparam logic [1:0] SRC_MEM_LD  = 2'b11;

  localparam logic [4:0]       REG_ZERO = 5'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Shadow of the instruction currently in EX.
  logic       r_e_wreg;
  logic       r_e_m2reg;
  logic [4:0] r_e_rn;
  // Shadow of the instruction currently in MEM.
  logic       r_m_wreg;
  logic       r_m_m2reg;
  logic [4:0] r_m_rn;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;

  // Per-operand view: index 0 is rs (drives da), index 1 is rt (drives db).
  logic [1:0][4:0] w_opnd;
  logic [1:0]      w_use;
  logic [1:0][1:0] w_src;
  logic [1:0]      w_haz;
  logic [1:0]      w_fwd_used;

  logic w_stall;
  logic w_fwd_event;
  logic w_e_live;
  logic w_m_live;

  assign w_opnd[0] = d_rs;
  assign w_opnd[1] = d_rt;
  assign w_use[0]  = d_use_rs;
  assign w_use[1]  = d_use_rt;

  // A stage can only be matched if it writes a real register ($0 is hardwired).
  assign w_e_live = r_e_wreg & (r_e_rn != REG_ZERO);
  assign w_m_live = r_m_wreg & (r_m_rn != REG_ZERO);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic w_hit_e;
      logic w_hit_m;

      assign w_hit_e = w_e_live & (r_e_rn == w_opnd[gi]);
      assign w_hit_m = w_m_live & (r_m_rn == w_opnd[gi]);

      if (BYPASS_EN) begin : g_byp
        // EX holds the younger writer, so it wins over MEM. A load still in
        // EX has no data yet: leave the source at the regfile and let the
        // stall cover it.
        assign w_src[gi] = (w_hit_e & ~r_e_m2reg) ? SRC_EX_ALU  :
                           (w_hit_e)              ? SRC_RF      :
                           (w_hit_m & r_m_m2reg)  ? SRC_MEM_LD  :
                           (w_hit_m)              ? SRC_MEM_ALU :
                                                    SRC_RF;
        // Only a used operand that depends on a load in EX must wait.
        assign w_haz[gi] = w_use[gi] & w_hit_e & r_e_m2reg;
      end else begin : g_nobyp
        // Without bypass paths every pending writer must drain to WB.
        assign w_src[gi] = SRC_RF;
        assign w_haz[gi] = w_use[gi] & (w_hit_e | w_hit_m);
      end

      assign w_fwd_used[gi] = w_use[gi] & (w_src[gi] != SRC_RF);
    end
  endgenerate

  assign w_stall     = |w_haz;
  // A stalled decode slot is re-presented next cycle, so it is not counted
  // as a forwarding event until it actually issues.
  assign w_fwd_event = ~w_stall & (|w_fwd_used);

  assign fwda      = w_src[0];
  assign fwdb      = w_src[1];
  assign wpcir     = ~w_stall;
  assign bubble    = w_stall;
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;

  // Advance the EX/MEM shadow; a bubble enters EX as a non-writing slot.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_e_rn    <= REG_ZERO;
      r_m_wreg  <= 1'b0;
      r_m_m2reg <= 1'b0;
      r_m_rn    <= REG_ZERO;
    end else begin
      if (w_stall) begin
        r_e_wreg  <= 1'b0;
        r_e_m2reg <= 1'b0;
        r_e_rn    <= REG_ZERO;
      end else begin
        r_e_wreg  <= d_wreg;
        r_e_m2reg <= d_m2reg;
        r_e_rn    <= d_rn;
      end
      r_m_wreg  <= r_e_wreg;
      r_m_m2reg <= r_e_m2reg;
      r_m_rn    <= r_e_rn;
    end
  end

  // Count stall cycles, sticking at all-ones.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  // Count issued cycles that consumed at least one bypassed operand, sticking at all-ones.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_fwd_cnt <= '0;
    end else if (w_fwd_event && (r_fwd_cnt != CNT_MAX)) begin
      r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three instances (bypass on, bypass off,
// 4-bit counters) share one stimulus stream and are compared every cycle
// against a pipeline-occupancy model; directed steps pin literal values.
module tb_pipe_hazard_unit;

  logic       clock;
  logic       resetn;
  logic [4:0] d_rs, d_rt, d_rn;
  logic       d_use_rs, d_use_rt, d_wreg, d_m2reg;

  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic        wp0, bb0, wp1, bb1, wp2, bb2;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  pipe_hazard_unit #(.CNT_W(32), .BYPASS_EN(1'b1)) u0 (
    .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .d_rn(d_rn), .fwda(fa0), .fwdb(fb0),
    .wpcir(wp0), .bubble(bb0), .stall_cnt(sc0), .fwd_cnt(fc0));

  pipe_hazard_unit #(.CNT_W(32), .BYPASS_EN(1'b0)) u1 (
    .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .d_rn(d_rn), .fwda(fa1), .fwdb(fb1),
    .wpcir(wp1), .bubble(bb1), .stall_cnt(sc1), .fwd_cnt(fc1));

  pipe_hazard_unit #(.CNT_W(4), .BYPASS_EN(1'b1)) u2 (
    .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .d_rn(d_rn), .fwda(fa2), .fwdb(fb2),
    .wpcir(wp2), .bubble(bb2), .stall_cnt(sc2), .fwd_cnt(fc2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       wreg;
    bit       m2reg;
    bit [4:0] rn;
  } stg_t;

  typedef struct packed {
    bit [1:0] fa;
    bit [1:0] fb;
    bit       st;
    bit       fw;
  } res_t;

  stg_t   m_ex  [3];
  stg_t   m_mem [3];
  longint m_sc  [3];
  longint m_fc  [3];
  bit     m_byp [3] = '{1'b1, 1'b0, 1'b1};
  longint m_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // Find the youngest in-flight writer of x and decide where its value comes from.
  function automatic void lookup(input stg_t ex, input stg_t mem, input bit [4:0] x,
                                 input bit byp, output bit [1:0] src, output bit haz);
    stg_t pipe [2];
    bit   found;
    pipe[0] = ex;
    pipe[1] = mem;
    src = 2'd0;
    haz = 1'b0;
    found = 1'b0;
    for (int age = 0; age < 2; age++) begin
      if (!found && pipe[age].wreg && x != 5'd0 && pipe[age].rn == x) begin
        found = 1'b1;
        if (!byp)                          haz = 1'b1;
        else if (age == 0 && pipe[age].m2reg) haz = 1'b1;
        else if (age == 0)                 src = 2'd1;
        else                               src = pipe[age].m2reg ? 2'd3 : 2'd2;
      end
    end
  endfunction

  function automatic res_t eval(input int k);
    res_t r;
    bit   ha, hb;
    lookup(m_ex[k], m_mem[k], d_rs, m_byp[k], r.fa, ha);
    lookup(m_ex[k], m_mem[k], d_rt, m_byp[k], r.fb, hb);
    r.st = (d_use_rs && ha) || (d_use_rt && hb);
    r.fw = !r.st && ((d_use_rs && r.fa != 0) || (d_use_rt && r.fb != 0));
    return r;
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      res_t r;
      r = eval(k);
      if (!resetn) begin
        m_ex[k]  <= '0;
        m_mem[k] <= '0;
        m_sc[k]  <= 0;
        m_fc[k]  <= 0;
      end else begin
        m_ex[k]  <= r.st ? stg_t'(0) : stg_t'({d_wreg, d_m2reg, d_rn});
        m_mem[k] <= m_ex[k];
        if (r.st && m_sc[k] < m_max[k]) m_sc[k] <= m_sc[k] + 1;
        if (r.fw && m_fc[k] < m_max[k]) m_fc[k] <= m_fc[k] + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [1:0] fa, input logic [1:0] fb,
                          input logic wp, input logic bb, input longint sc, input longint fc);
    res_t r;
    r = eval(k);
    chk($sformatf("u%0d.fwda", k), longint'(fa), longint'(r.fa));
    chk($sformatf("u%0d.fwdb", k), longint'(fb), longint'(r.fb));
    chk($sformatf("u%0d.wpcir", k), longint'(wp), longint'(!r.st));
    chk($sformatf("u%0d.bubble", k), longint'(bb), longint'(r.st));
    chk($sformatf("u%0d.stall_cnt", k), sc, m_sc[k]);
    chk($sformatf("u%0d.fwd_cnt", k), fc, m_fc[k]);
  endtask

  // Compare every instance against the model in the middle of each cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      cmp_inst(0, fa0, fb0, wp0, bb0, longint'(sc0), longint'(fc0));
      cmp_inst(1, fa1, fb1, wp1, bb1, longint'(sc1), longint'(fc1));
      cmp_inst(2, fa2, fb2, wp2, bb2, longint'(sc2), longint'(fc2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int rs, input int rt, input int urs, input int urt,
                        input int wr, input int m2, input int rn);
    d_rs     = rs[4:0];
    d_rt     = rt[4:0];
    d_use_rs = urs[0];
    d_use_rt = urt[0];
    d_wreg   = wr[0];
    d_m2reg  = m2[0];
    d_rn     = rn[4:0];
  endtask

  task automatic set_random();
    set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7));
  endtask

  initial begin
    // 1: reset with random decode inputs, then idle
    resetn = 1'b0;
    set_in($urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 1, 1, $urandom_range(0, 31));
    next_cycle();
    set_random();
    next_cycle();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst.wpcir", longint'(wp0), 1);
    chk("rst.bubble", longint'(bb0), 0);
    chk("rst.fwda", longint'(fa0), 0);
    chk("rst.fwdb", longint'(fb0), 0);
    chk("rst.stall_cnt", longint'(sc0), 0);
    chk("rst.fwd_cnt", longint'(fc0), 0);

    // 2: ALU chain, EX bypass then MEM bypass
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 3);
    next_cycle();
    set_in(3, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("alu.fwda_ex", longint'(fa0), 1);
    next_cycle();
    chk("alu.fwd_cnt", longint'(fc0), 1);
    set_in(0, 3, 0, 1, 0, 0, 0);
    @(negedge clock);
    chk("alu.fwdb_mem", longint'(fb0), 2);

    // 3: load-use costs one cycle, then MEM load data is bypassed
    next_cycle();
    set_in(0, 0, 0, 0, 1, 1, 5);
    next_cycle();
    set_in(0, 5, 0, 1, 0, 0, 0);
    @(negedge clock);
    chk("ld.wpcir_stall", longint'(wp0), 0);
    chk("ld.bubble_stall", longint'(bb0), 1);
    next_cycle();
    @(negedge clock);
    chk("ld.wpcir_go", longint'(wp0), 1);
    chk("ld.fwdb_load", longint'(fb0), 3);
    next_cycle();
    chk("ld.stall_cnt", longint'(sc0), 1);
    chk("ld.fwd_cnt", longint'(fc0), 3);

    // 4: $0 never matches; EX wins over MEM
    set_in(0, 0, 0, 0, 1, 0, 0);
    next_cycle();
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("r0.fwda", longint'(fa0), 0);
    chk("r0.wpcir", longint'(wp0), 1);
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 7);
    next_cycle();
    next_cycle();
    set_in(7, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("prio.fwda", longint'(fa0), 1);

    // 5: without bypass an ALU RAW hazard stalls twice
    next_cycle();
    resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 1, 0, 4);
    next_cycle();
    set_in(4, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("nb.wpcir_1", longint'(wp1), 0);
    next_cycle();
    @(negedge clock);
    chk("nb.wpcir_2", longint'(wp1), 0);
    next_cycle();
    @(negedge clock);
    chk("nb.wpcir_3", longint'(wp1), 1);
    chk("nb.fwda", longint'(fa1), 0);
    next_cycle();
    chk("nb.stall_cnt", longint'(sc1), 2);

    // 6: twenty load-use stalls saturate the 4-bit counter, then reset mid-stall
    resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    resetn = 1'b1;
    set_in(0, 5, 0, 1, 1, 1, 5);
    repeat (40) next_cycle();
    chk("sat.stall_cnt4", longint'(sc2), 15);
    chk("sat.stall_cnt32", longint'(sc0), 20);
    next_cycle();
    @(negedge clock);
    chk("rstmid.bubble_before", longint'(bb0), 1);
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    chk("rstmid.stall_cnt", longint'(sc0), 0);
    @(negedge clock);
    chk("rstmid.bubble", longint'(bb0), 0);
    chk("rstmid.wpcir", longint'(wp0), 1);

    // Random traffic over a small register window to provoke collisions
    repeat (3000) begin
      next_cycle();
      resetn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) != 0) set_random();
    end
    next_cycle();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
